mem_bus_master: RTL and testbench

- Initiator for the single-beat memory-mapped bus (addr/wdata/wen/ren out, rdata/valid in) served by the memory and FIFO targets.
- Accepts one command at a time from a requester over a valid/ready handshake and drives exactly one bus strobe per command.
- For reads, waits for the target's valid, with a timeout.
- Returns a response (read data or write acknowledge, plus error flag) over a valid/ready handshake.

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_master.sv | 150 +++++++++++++++
 tb/tb_mem_bus_master.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the single-beat memory bus master
// and the requesters that feed it.
package mem_bus_pkg;

    localparam int TIMER_W    = 8;
    localparam int CMD_ADDR_W = 16;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } master_state_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_bus_master.sv
// Single-beat bus initiator: one command in, one strobe out, one response
// back. Reads wait for the target's valid under a bounded timer.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wen,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  valid
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_bus_master: TIMEOUT must be in 1..255");
    end

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    master_state_t state_q, state_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic                  ren_q, ren_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    // Gated by rst so the requester sees no ready while reset is held.
    assign cmd_ready = (state_q == IDLE) && !rst;

    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        timer_d     = timer_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_write_d = cmd_write;
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    wen_d      = cmd_write;
                    ren_d      = !cmd_write;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (op_write_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                    state_d     = RESP;
                end else begin
                    timer_d = '0;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                timer_d = timer_q + 1'b1;
                // A valid in the last timer cycle still counts as success.
                if (valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_error_d = 1'b0;
                    state_d     = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            timer_q     <= timer_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign wen       = wen_q;
    assign ren       = ren_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: timeline model of each transaction plus
// a small memory target, checked against the DUT every cycle.
module tb_mem_bus_master;
    import mem_bus_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata = '0;
    logic        valid = 1'b0;

    mem_bus_master #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .addr(addr), .wdata(wdata), .wen(wen), .ren(ren),
        .rdata(rdata), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        cmd_t c;
        int   d;
    } job_t;

    job_t jobq[$];
    int   hs_log[$];
    logic [31:0] mem [16];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int gap_pct = 0;
    int rdy_pct = 100;
    bit noise_en = 1'b0;
    bit force_valid = 1'b0;

    // transaction timeline model
    bit          busy = 1'b0;
    int          m_hs = -10;
    int          rsp_start = 0;
    int          m_d = 0;
    bit          m_write = 1'b0;
    bit          rd_ok = 1'b0;
    logic [15:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    bit          e_rw = 1'b0;
    bit          e_err = 1'b0;
    logic [31:0] e_rd = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    function automatic job_t mk(input bit w, input logic [15:0] a,
                                input logic [31:0] wd, input int d);
        job_t j;
        j.c.write = w;
        j.c.addr  = a;
        j.c.wdata = wd;
        j.d       = d;
        return j;
    endfunction

    task automatic accept(input int h);
        job_t j;
        j = jobq.pop_front();
        busy    = 1'b1;
        m_hs    = h;
        m_write = j.c.write;
        m_addr  = j.c.addr;
        m_wdata = j.c.wdata;
        m_d     = j.d;
        hs_log.push_back(h);
        if (m_write) begin
            mem[m_addr[3:0]] = m_wdata;
            rsp_start = h + 2;
            e_rw  = 1'b1;
            e_err = 1'b0;
            e_rd  = '0;
        end else begin
            rd_ok = (m_d >= 1) && (m_d <= TO);
            rsp_start = h + 2 + (rd_ok ? m_d : TO);
            e_rw  = 1'b0;
            e_err = !rd_ok;
            e_rd  = rd_ok ? mem[m_addr[3:0]] : 32'h0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            if (!busy) begin
                if (cmd_valid) accept(cyc - 1);
            end else if (cyc - 1 >= rsp_start && rsp_ready) begin
                busy = 1'b0;
            end
        end
        if (jobq.size() > 0 && $urandom_range(99) >= gap_pct) begin
            cmd_valid = 1'b1;
            cmd_write = jobq[0].c.write;
            cmd_addr  = jobq[0].c.addr;
            cmd_wdata = jobq[0].c.wdata;
        end else begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = 16'($urandom);
            cmd_wdata = $urandom;
        end
        rsp_ready = ($urandom_range(99) < rdy_pct);
        rdata = $urandom;
        if (force_valid) begin
            valid = 1'b1;
        end else if (busy && !m_write && rd_ok && cyc == m_hs + 1 + m_d) begin
            valid = 1'b1;
            rdata = mem[m_addr[3:0]];
        end else if (noise_en && (!busy || cyc == m_hs + 1)) begin
            valid = 1'($urandom);
        end else begin
            valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int maxc, output int lat);
        lat = -1;
        for (int i = 0; i < maxc; i++) begin
            step();
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = cyc - m_hs;
                return;
            end
        end
        n_chk++;
        $display("FAIL rsp_wait: no rsp_valid within %0d cycles", maxc);
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin : cmp
        bit e_rv;
        bit e_wen;
        bit e_ren;
        if (chk_en) begin
            e_rv  = busy && (cyc >= rsp_start);
            e_wen = busy && m_write && (cyc == m_hs + 1);
            e_ren = busy && !m_write && (cyc == m_hs + 1);
            chk("ctrl", {cmd_ready, wen, ren, rsp_valid},
                {!busy, e_wen, e_ren, e_rv});
            chk("bus", {addr, wdata}, {m_addr, m_wdata});
            if (e_rv)
                chk("rsp", {rsp_write, rsp_rdata, rsp_error},
                    {e_rw, e_rd, e_err});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_ctrl", {cmd_ready, rsp_valid, rsp_write, rsp_error,
                           wen, ren, rsp_rdata}, 64'h0);
        chk("reset_bus", {addr, wdata}, 64'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // single write
        jobq.push_back(mk(1'b1, 16'h0010, 32'hDEADBEEF, 0));
        step();
        step();
        @(negedge clk);
        chk("wr_strobe", {wen, ren}, 2'b10);
        chk("wr_bus", {addr, wdata}, {16'h0010, 32'hDEADBEEF});
        wait_rsp(10, lat);
        chk("wr_lat", lat, 2);
        chk("wr_rsp", {rsp_write, rsp_error, rsp_rdata}, {2'b10, 32'h0});

        // write then read back
        jobq.push_back(mk(1'b1, 16'h0004, 32'hCAFEF00D, 0));
        jobq.push_back(mk(1'b0, 16'h0004, 32'h0, 1));
        wait_rsp(10, lat);
        wait_rsp(10, lat);
        chk("rd_lat", lat, 3);
        chk("rd_rsp", {rsp_write, rsp_error, rsp_rdata},
            {2'b00, 32'hCAFEF00D});

        // timeout, then valid in the last waiting cycle
        jobq.push_back(mk(1'b0, 16'h0040, 32'h0, 0));
        wait_rsp(40, lat);
        chk("to_lat", lat, 17);
        chk("to_rsp", {rsp_error, rsp_rdata}, {1'b1, 32'h0});
        jobq.push_back(mk(1'b1, 16'h0008, 32'h12345678, 0));
        jobq.push_back(mk(1'b0, 16'h0008, 32'h0, TO));
        wait_rsp(10, lat);
        wait_rsp(40, lat);
        chk("late_lat", lat, 17);
        chk("late_rsp", {rsp_error, rsp_rdata}, {1'b0, 32'h12345678});

        // response backpressure
        rdy_pct = 0;
        jobq.push_back(mk(1'b1, 16'h0020, 32'h11111111, 0));
        jobq.push_back(mk(1'b1, 16'h0024, 32'h22222222, 0));
        wait_rsp(10, lat);
        repeat (5) step();
        @(negedge clk);
        chk("bp_hold", {rsp_valid, cmd_ready, wen}, 3'b100);
        rdy_pct = 100;
        step();
        step();
        @(negedge clk);
        chk("bp_release", {cmd_ready, rsp_valid}, 2'b10);
        step();
        @(negedge clk);
        chk("bp_next", {wen, addr}, {1'b1, 16'h0024});
        wait_rsp(10, lat);

        // back-to-back alternating commands
        step();
        hs_log.delete();
        jobq.push_back(mk(1'b1, 16'h0030, 32'hAAAA0001, 0));
        jobq.push_back(mk(1'b0, 16'h0030, 32'h0, 1));
        jobq.push_back(mk(1'b1, 16'h0034, 32'hAAAA0002, 0));
        jobq.push_back(mk(1'b0, 16'h0034, 32'h0, 1));
        n = 0;
        while ((jobq.size() > 0 || busy) && n < 60) begin
            step();
            n++;
        end
        chk("b2b_count", hs_log.size(), 4);
        if (hs_log.size() == 4) begin
            chk("b2b_gap0", hs_log[1] - hs_log[0], 3);
            chk("b2b_gap1", hs_log[2] - hs_log[1], 4);
            chk("b2b_gap2", hs_log[3] - hs_log[2], 3);
        end

        // reset while waiting for read data
        jobq.push_back(mk(1'b0, 16'h0050, 32'h0, 0));
        repeat (5) step();
        #1;
        rst = 1'b1;
        chk_en = 1'b0;
        #1;
        chk("arst_ctrl", {cmd_ready, rsp_valid, rsp_write, rsp_error,
                          wen, ren, rsp_rdata}, 64'h0);
        chk("arst_bus", {addr, wdata}, 64'h0);
        busy = 1'b0;
        m_addr = '0;
        m_wdata = '0;
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        force_valid = 1'b1;
        repeat (3) step();
        force_valid = 1'b0;
        @(negedge clk);
        chk("arst_late_valid", {rsp_valid, cmd_ready}, 2'b01);

        // randomized traffic
        noise_en = 1'b1;
        gap_pct = 20;
        rdy_pct = 70;
        for (int i = 0; i < 300; i++) begin
            int d;
            d = ($urandom_range(9) == 0) ? int'($urandom_range(17))
                                         : int'($urandom_range(3, 1));
            jobq.push_back(mk(1'($urandom), 16'($urandom), $urandom, d));
        end
        n = 0;
        while ((jobq.size() > 0 || busy) && n < 20000) begin
            step();
            n++;
        end
        if (n >= 20000) begin
            n_chk++;
            $display("FAIL random_drain: %0d jobs left after %0d cycles",
                     jobq.size(), n);
        end
        step();
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
